// File: rtl/lzd_normalizer.sv
// lzd_normalizer: two-stage valid/ready pipeline that left-justifies an
// unsigned integer and reports the bit position of its leading one.
// Stage 1 registers the input together with its leading-zero count; stage 2
// applies that count as a left shift and derives the exponent.
module lzd_normalizer #(
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_mant,
    output logic [$clog2(WIDTH)-1:0] out_exp,
    output logic                     out_zero
);

    localparam int CW = $clog2(WIDTH);

    // Stage 1 holding register
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [CW-1:0]    s1_zcnt;
    logic             s1_zero;

    // Combinational leading-zero count of the incoming word
    logic [CW-1:0]    lz_cnt;
    logic             lz_found;
    logic             lz_zero;

    // Handshake controls
    logic             s1_load;
    logic             s2_load;
    logic             s1_ready;

    // Leading-zero count: first set bit scanning from the MSB; zero input yields 0.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        lz_cnt   = '0;
        lz_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!lz_found && in_data[i]) begin
                lz_cnt   = CW'(WIDTH - 1 - i);
                lz_found = 1'b1;
            end
        end
        lz_zero = (in_data == '0);
    end

    // Stage 2 loads when its slot is empty or draining this cycle; stage 1
    // accepts when empty or handing its item to stage 2 this cycle.
    always_comb begin
        s2_load  = s1_valid & (~out_valid | out_ready);
        s1_ready = ~s1_valid | s2_load;
        s1_load  = in_valid & s1_ready;
        in_ready = s1_ready;
    end

    // Stage 1 register: capture input word and its leading-zero count.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            // NOTE: the data registers are reset as well as the valid bit so
            // the outputs come up as defined zeros rather than X.
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_zcnt  <= '0;
            s1_zero  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_zcnt  <= lz_cnt;
                s1_zero  <= lz_zero;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 register: shift to normalize and form the exponent; holds while stalled.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_zero  <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= 1'b1;
                out_mant  <= s1_data << s1_zcnt;
                out_exp   <= s1_zero ? '0 : (CW'(WIDTH - 1) - s1_zcnt);
                out_zero  <= s1_zero;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
